// File: rtl/calc_pkg.sv
// Shared constants, operator encodings and sequencer state type for the calculator ALU.
package calc_pkg;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        MUL,
        FIN
    } alu_state_t;

endpackage

// File: rtl/calc_mul_core.sv
// Iterative unsigned shift-add multiplier: one partial product per step, magnitudes only.
module calc_mul_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign product = acc_q;

endmodule

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle signed add/sub/mul engine with done pulse and overflow/error flags.
// Build option: define CALC_ALU_SAT_EN to saturate the result on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; last result/flags held
// LOAD  | decode latched op; load multiplier magnitudes for mul
// EXEC  | single-cycle add/sub, result registered
// MUL   | one shift-add per cycle; extra cycle at count==WIDTH resolves sign/overflow
// FIN   | done pulse, then back to IDLE
module calc_alu_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH  = calc_pkg::WIDTH,
    parameter int ITER_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             err
);

    localparam logic [2*WIDTH-1:0] MAX_POS     = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] MAX_NEG_MAG = MAX_POS + 1'b1;

    alu_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               err_q, err_d;

    logic               mul_load, mul_step;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] product, neg_product;
    logic [WIDTH:0]     sum_ext;
    logic               mul_ovf;

    // Wrap by default; with saturation, clamp toward the sign of the true result.
    function automatic logic [WIDTH-1:0] final_value(input logic [WIDTH-1:0] wrapped,
                                                     input logic ovf, input logic neg);
`ifdef CALC_ALU_SAT_EN
        if (ovf) begin
            return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return wrapped;
`else
        return (ovf & neg & 1'b0) ? '0 : wrapped;
`endif
    endfunction

    assign mag_a = a_q[WIDTH-1] ? WIDTH'(-a_q) : a_q;
    assign mag_b = b_q[WIDTH-1] ? WIDTH'(-b_q) : b_q;

    calc_mul_core #(.WIDTH(WIDTH)) u_mul_core (
        .clk     (clk),
        .rst     (RST),
        .load    (mul_load),
        .step    (mul_step),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .product (product)
    );

    assign neg_product = -product;
    assign mul_ovf     = sign_q ? (product > MAX_NEG_MAG) : (product > MAX_POS);
    assign sum_ext     = (op_q == OP_SUB) ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                                          : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        mul_load   = 1'b0;
        mul_step   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d        = operand_a;
                    b_d        = operand_b;
                    op_d       = op;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                case (op_q)
                    OP_ADD, OP_SUB: state_d = EXEC;
                    OP_MUL: begin
                        mul_load = 1'b1;
                        sign_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        cnt_d    = '0;
                        state_d  = MUL;
                    end
                    default: begin
                        err_d      = 1'b1;
                        result_d   = '0;
                        overflow_d = 1'b0;
                        state_d    = FIN;
                    end
                endcase
            end
            EXEC: begin
                // Signed overflow shows as disagreement between the extended sign and result MSB.
                overflow_d = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
                result_d   = final_value(sum_ext[WIDTH-1:0], overflow_d, sum_ext[WIDTH]);
                state_d    = FIN;
            end
            MUL: begin
                if (cnt_q == ITER_W'(WIDTH)) begin
                    overflow_d = mul_ovf;
                    result_d   = final_value(sign_q ? neg_product[WIDTH-1:0] : product[WIDTH-1:0],
                                             mul_ovf, sign_q);
                    state_d    = FIN;
                end else begin
                    mul_step = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign result   = result_q;
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule
